// File: rtl/pdm_xcorr_lag_if.sv
// pdm_xcorr_lag_if: sample stream and best-lag result port of pdm_xcorr_lag.
// The anti-correlation fields exist only when XCORR_ANTI_EN is defined.
// Handshake: a result transfers on a rising clk edge where out_valid and
// out_ready are both 1. out_valid never drops and best_lag/best_count never
// change before that edge. in_valid has no back-pressure: every in_valid
// cycle is one sample.
interface pdm_xcorr_lag_if #(
    parameter int CW = 9,
    parameter int LW = 4
);
    logic                 in_valid;
    logic                 data_1;
    logic                 data_2;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [LW-1:0] best_lag;
    logic        [CW-1:0] best_count;
`ifdef XCORR_ANTI_EN
    logic signed [LW-1:0] anti_lag;
    logic        [CW-1:0] anti_count;

    modport master (output in_valid, data_1, data_2, out_ready,
                    input  out_valid, best_lag, best_count, anti_lag, anti_count);
    modport slave  (input  in_valid, data_1, data_2, out_ready,
                    output out_valid, best_lag, best_count, anti_lag, anti_count);
`else
    modport master (output in_valid, data_1, data_2, out_ready,
                    input  out_valid, best_lag, best_count);
    modport slave  (input  in_valid, data_1, data_2, out_ready,
                    output out_valid, best_lag, best_count);
`endif
endinterface

// File: rtl/pdm_xcorr_lag.sv
// pdm_xcorr_lag: sliding-window XOR cross-correlator for two PDM bit streams.
// One mismatch count is kept per lag in -MAX_LAG..+MAX_LAG. On req, a scan
// FSM walks a snapshot of the counts and reports the lag with the fewest
// mismatches. Ties go to the most negative lag.
// Optional feature macro: XCORR_ANTI_EN. When it is defined, the same scan
// also reports the lag with the most mismatches (anti_lag/anti_count).
// state_o exposes the FSM state: 0 IDLE, 1 SCAN, 2 DONE.
module pdm_xcorr_lag #(
    parameter int WIN_MAX = 256,
    parameter int MAX_LAG = 4,
    parameter int CW      = $clog2(WIN_MAX + 1),
    parameter int LW      = $clog2(MAX_LAG + 1) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [CW-1:0]  win_len,
    input  logic           clear,
    input  logic           req,
    output logic           filled,
    output logic           busy,
    output logic [1:0]     state_o,
    pdm_xcorr_lag_if.slave bus
);
    localparam int NLAG = 2 * MAX_LAG + 1;
    localparam int D    = WIN_MAX + 2 * MAX_LAG + 1;  // post-shift history depth
    localparam int HW   = $clog2(D);                  // history index / fill width
    localparam int IW   = $clog2(NLAG + 1);           // scan index, one past last lag

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

    // The oldest post-shift bit is read only combinationally. It falls out on
    // the next shift, so the registers hold D-1 bits.
    logic [D-2:0]  h1_q, h1_d, h2_q, h2_d;
    logic [D-1:0]  h1_n, h2_n;
    logic [CW-1:0] cnt_q [NLAG];
    logic [CW-1:0] cnt_d [NLAG];
    logic [HW-1:0] fill_q, fill_d, fill_end, h2_drop_idx;
    logic [CW-1:0] w_q, w_d;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        snap_q [NLAG];
    logic [CW-1:0]        snap_d [NLAG];
    logic [CW-1:0]        min_cnt_q, min_cnt_d, best_cnt_q, best_cnt_d, cur_cnt;
    logic signed [LW-1:0] min_lag_q, min_lag_d, best_lag_q, best_lag_d, cur_lag;
`ifdef XCORR_ANTI_EN
    logic [CW-1:0]        max_cnt_q, max_cnt_d, anti_cnt_q, anti_cnt_d;
    logic signed [LW-1:0] max_lag_q, max_lag_d, anti_lag_q, anti_lag_d;
`endif

    assign h1_n        = {h1_q, bus.data_1};
    assign h2_n        = {h2_q, bus.data_2};
    assign fill_end    = HW'(w_q) + HW'(2 * MAX_LAG);
    assign h2_drop_idx = HW'(MAX_LAG) + HW'(w_q);
    assign filled      = (fill_q == fill_end);

    // History shift, per-lag count update (+add -drop), fill counter, window latch.
    always_comb begin
        h1_d   = h1_q;
        h2_d   = h2_q;
        fill_d = fill_q;
        w_d    = w_q;
        for (int k = 0; k < NLAG; k++) cnt_d[k] = cnt_q[k];
        if (clear) begin
            h1_d   = '0;
            h2_d   = '0;
            fill_d = '0;
            for (int k = 0; k < NLAG; k++) cnt_d[k] = '0;
            if (win_len == '0)                 w_d = CW'(1);
            else if (win_len > CW'(WIN_MAX))   w_d = CW'(WIN_MAX);
            else                               w_d = win_len;
        end else if (bus.in_valid) begin
            h1_d = h1_n[D-2:0];
            h2_d = h2_n[D-2:0];
            if (fill_q != fill_end) fill_d = fill_q + 1'b1;
            // Lag index k maps to lag k-MAX_LAG, so h1 add index is MAX_LAG+lag = k.
            // Widen by one bit: count+add can reach W+1 before the drop lands.
            for (int k = 0; k < NLAG; k++) begin
                cnt_d[k] = CW'({1'b0, cnt_q[k]}
                              + {{CW{1'b0}}, h1_n[k] ^ h2_n[MAX_LAG]}
                              - {{CW{1'b0}}, h1_n[HW'(k) + HW'(w_q)] ^ h2_n[h2_drop_idx]});
            end
        end
    end

    // Datapath registers. The window resets to its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q   <= '0;
            h2_q   <= '0;
            fill_q <= '0;
            w_q    <= CW'(WIN_MAX);
            for (int k = 0; k < NLAG; k++) cnt_q[k] <= '0;
        end else begin
            h1_q   <= h1_d;
            h2_q   <= h2_d;
            fill_q <= fill_d;
            w_q    <= w_d;
            for (int k = 0; k < NLAG; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign cur_lag = LW'(idx_q) - LW'(MAX_LAG);
    assign cur_cnt = (idx_q < IW'(NLAG)) ? snap_q[idx_q] : '0;

    // Scan FSM. SCAN compares lags 1..NLAG-1 and spends one more cycle
    // publishing the result, so out_valid rises NLAG edges after req.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        min_cnt_d  = min_cnt_q;
        min_lag_d  = min_lag_q;
        best_cnt_d = best_cnt_q;
        best_lag_d = best_lag_q;
        for (int k = 0; k < NLAG; k++) snap_d[k] = snap_q[k];
`ifdef XCORR_ANTI_EN
        max_cnt_d  = max_cnt_q;
        max_lag_d  = max_lag_q;
        anti_cnt_d = anti_cnt_q;
        anti_lag_d = anti_lag_q;
`endif
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (req && filled) begin
                    state_d = SCAN;
                    for (int k = 0; k < NLAG; k++) snap_d[k] = cnt_q[k];
                    idx_d     = IW'(1);
                    min_cnt_d = cnt_q[0];
                    min_lag_d = -LW'(MAX_LAG);
`ifdef XCORR_ANTI_EN
                    max_cnt_d = cnt_q[0];
                    max_lag_d = -LW'(MAX_LAG);
`endif
                end
                SCAN: if (idx_q == IW'(NLAG)) begin
                    state_d    = DONE;
                    best_cnt_d = min_cnt_q;
                    best_lag_d = min_lag_q;
`ifdef XCORR_ANTI_EN
                    anti_cnt_d = max_cnt_q;
                    anti_lag_d = max_lag_q;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (cur_cnt < min_cnt_q) begin
                        min_cnt_d = cur_cnt;
                        min_lag_d = cur_lag;
                    end
`ifdef XCORR_ANTI_EN
                    if (cur_cnt > max_cnt_q) begin
                        max_cnt_d = cur_cnt;
                        max_lag_d = cur_lag;
                    end
`endif
                end
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state, snapshot and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            min_cnt_q  <= '0;
            min_lag_q  <= '0;
            best_cnt_q <= '0;
            best_lag_q <= '0;
            for (int k = 0; k < NLAG; k++) snap_q[k] <= '0;
`ifdef XCORR_ANTI_EN
            max_cnt_q  <= '0;
            max_lag_q  <= '0;
            anti_cnt_q <= '0;
            anti_lag_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            min_cnt_q  <= min_cnt_d;
            min_lag_q  <= min_lag_d;
            best_cnt_q <= best_cnt_d;
            best_lag_q <= best_lag_d;
            for (int k = 0; k < NLAG; k++) snap_q[k] <= snap_d[k];
`ifdef XCORR_ANTI_EN
            max_cnt_q  <= max_cnt_d;
            max_lag_q  <= max_lag_d;
            anti_cnt_q <= anti_cnt_d;
            anti_lag_q <= anti_lag_d;
`endif
        end
    end

    assign busy           = (state_q != IDLE);
    assign state_o        = state_q;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.best_lag   = best_lag_q;
    assign bus.best_count = best_cnt_q;
`ifdef XCORR_ANTI_EN
    assign bus.anti_lag   = anti_lag_q;
    assign bus.anti_count = anti_cnt_q;
`endif
endmodule

// File: doc/pdm_xcorr_lag.md
# pdm_xcorr_lag

Multi-lag sliding-window cross-correlator for two 1-bit PDM streams. It keeps one XOR mismatch count per lag over a runtime-selectable window, for lags −MAX_LAG..+MAX_LAG. On request, an FSM scans the count snapshot and reports the lag with the fewest mismatches, which is the best time alignment. It sits directly behind the PDM microphone capture and feeds the direction/delay estimator through a valid/ready result port.

## Interface
- `WIN_MAX`, 256: maximum window length in samples (≥2).
- `MAX_LAG`, 4: maximum lag magnitude (≥1); number of lags is NLAG = 2·MAX_LAG+1.
- `CW`, $clog2(WIN_MAX+1): width of counts and of `win_len`.
- `LW`, $clog2(MAX_LAG+1)+1: signed lag width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `data_1`/`data_2` hold a new sample this cycle.
- `data_1`  in  1  channel 1 PDM bit.
- `data_2`  in  1  channel 2 PDM bit.
- `win_len`  in  CW  window length; latched only on `clear`.
- `clear`  in  1  synchronous flush of history, counts and fill, plus abort of any scan.
- `req`  in  1  request a best-lag result.
- `filled`  out  1  all counts cover a full window.
- `busy`  out  1  FSM in SCAN or DONE.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `best_lag`  out  LW  signed lag with minimum count.
- `best_count`  out  CW  that minimum count.

## Operation
- History: shift registers h1 and h2, each WIN_MAX+2·MAX_LAG+1 bits deep. h[0] is the newest bit. They shift only when `in_valid` is high.
- Lag k is in −MAX_LAG..+MAX_LAG. The add term is e_k = h1[MAX_LAG+k] ^ h2[MAX_LAG], using post-shift indexing. The drop term uses the same indices plus W.
- Positive k means `data_2` lags `data_1` by k samples.
- Count update on each valid sample: c_k ← c_k + add − drop, computed in a single registered expression per lag.
- W is the latched window. `win_len` of 0 is treated as 1; values above WIN_MAX are clamped to WIN_MAX.
- Count range is 0..W. No wrap can occur, so counts carry no saturation logic.
- Fill counter: counts valid samples since `clear` or reset and stops at W+2·MAX_LAG. `filled` is 1 when the counter reaches that value.
- FSM states:
  - IDLE: `req`·`filled` → SCAN. On that edge, snapshot all NLAG counts and load the running minimum with lag −MAX_LAG.
  - SCAN: one lag per cycle, in order −MAX_LAG+1 .. +MAX_LAG. Replace the minimum only when the count is strictly less, so ties go to the most negative lag. After the last lag → DONE.
  - DONE: `out_valid`=1. `out_ready` → IDLE.
- `req` outside IDLE, or with `filled`=0, is ignored (not queued).
- Counters keep updating during SCAN and DONE; the scan uses the snapshot only.
- `clear` has priority over everything: the FSM goes to IDLE, `out_valid` drops, history, counts and fill go to 0, and `win_len` is latched.
- `clear` together with `in_valid`: the sample is discarded.

## Timing
- Reset values:
  - `filled`, `busy`, `out_valid`: 0.
  - `best_lag`, `best_count`: 0.
  - All counts, history and fill: 0.
  - FSM: IDLE.
  - Latched W: WIN_MAX.
- Count update: one cycle after a valid sample.
- `filled` rises on the edge that takes in valid sample number W+2·MAX_LAG.
- Result latency: `req` sampled at edge N, then `out_valid` is high after edge N+NLAG.
- `out_valid` and the result are held stable until the edge where `out_ready`=1. `out_valid` falls after that edge.
- Earliest next accepted `req` is the cycle after the handshake.
- Asynchronous reset mid-scan: immediate return to reset values.

## Configuration
- `XCORR_ANTI_EN` defined:
  - Adds outputs `anti_lag` (LW) and `anti_count` (CW), both reset to 0.
  - The scan also tracks the strict-greater maximum in the same pass, with ties going to the most negative lag.
  - They are valid with `out_valid`.
- `XCORR_ANTI_EN` undefined: the ports and the maximum logic are absent; everything else is identical.

## Test plan
All scenarios use MAX_LAG=4 and WIN_MAX=256.
- Reset: drive `rst_n`=0 mid-stream → all outputs 0 and FSM IDLE. After release, `req` is ignored until `filled`.
- Delay detect: `clear` with `win_len`=64; random `data_1`; `data_2` = `data_1` delayed 3 samples; 72 valid samples; `req` → after 9 cycles, `best_lag`=+3, `best_count`=0.
- Constant disagreement: `data_1`=1, `data_2`=0, W=64 → every count is 64, `best_lag`=−4, `best_count`=64. With `XCORR_ANTI_EN`: `anti_lag`=−4, `anti_count`=64.
- Window clamp/fill: `clear` with `win_len`=0 → `filled` after 9 valid samples. `win_len`=300 → W=256, `filled` after 264 samples. `in_valid` gaps freeze the counts and the fill counter.
- Handshake: hold `out_ready`=0 for 20 cycles → result stable and `out_valid` held. A `req` pulsed during SCAN and DONE produces no second result.
- Abort: `clear` during SCAN → next cycle IDLE, `out_valid`=0, counts 0, `filled`=0.
